// File: rtl/pit_pkg.sv
// Shared types and constants for the point-in-triangle block.
// Holds coordinate/sign widths, FSM state encoding, slot indices and the inside-rule helper.
// Optional build macro EDGE_STRICT_EN: when defined, points on an edge (any zero sign) count as outside.
package pit_pkg;

   // Coordinate width and the signed width of one edge cross-product.
   localparam int W  = 10;
   localparam int SW = 2*W + 3;

   // FSM states: collecting points, serial sign evaluation, result held.
   typedef enum logic [1:0] {
      LOAD = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Point slot indices; pointIdx walks P1 -> P2 -> P3 -> PT.
   localparam logic [1:0] P1 = 2'd0;
   localparam logic [1:0] P2 = 2'd1;
   localparam logic [1:0] P3 = 2'd2;
   localparam logic [1:0] PT = 2'd3;

   // Inside decision from the three edge signs. Mixed signs mean the point
   // is outside; a zero sign means the point sits on an edge line.
   function automatic logic pit_inside(input logic signed [SW-1:0] s1,
                                       input logic signed [SW-1:0] s2,
                                       input logic signed [SW-1:0] s3);
      logic neg;
      logic pos;
      neg = s1[SW-1] | s2[SW-1] | s3[SW-1];
      pos = (!s1[SW-1] && (s1 != '0)) ||
            (!s2[SW-1] && (s2 != '0)) ||
            (!s3[SW-1] && (s3 != '0));
`ifdef EDGE_STRICT_EN
      return ~(neg & pos) & ~((s1 == '0) | (s2 == '0) | (s3 == '0));
`else
      return ~(neg & pos);
`endif
   endfunction

endpackage

// File: rtl/point_in_triangle_edge_sign.sv
// Edge sign: d = (ax-cx)*(by-cy) - (bx-cx)*(ay-cy), full precision, signed SW bits.
// Latency: purely combinational.
// Backpressure: none; operands are muxed in by the caller every cycle.
module edge_sign
   import pit_pkg::*;
(
   input  logic [W-1:0]          ax,
   input  logic [W-1:0]          ay,
   input  logic [W-1:0]          bx,
   input  logic [W-1:0]          by,
   input  logic [W-1:0]          cx,
   input  logic [W-1:0]          cy,
   output logic signed [SW-1:0]  d
);

   // Differences of two unsigned W-bit values always fit in W+1 signed bits.
   logic signed [W:0]     dx_ac;
   logic signed [W:0]     dy_bc;
   logic signed [W:0]     dx_bc;
   logic signed [W:0]     dy_ac;

   // Products of two W+1-bit signed values fit in 2W+2 bits without wrap.
   logic signed [2*W+1:0] prod_a;
   logic signed [2*W+1:0] prod_b;

   // Subtraction of two 2W+2-bit products needs one extra bit to stay exact.
   logic signed [SW-1:0]  prod_a_x;
   logic signed [SW-1:0]  prod_b_x;

   // Operand differences and the two cross-product terms.
   always_comb begin
      dx_ac    = $signed({1'b0, ax}) - $signed({1'b0, cx});
      dy_bc    = $signed({1'b0, by}) - $signed({1'b0, cy});
      dx_bc    = $signed({1'b0, bx}) - $signed({1'b0, cx});
      dy_ac    = $signed({1'b0, ay}) - $signed({1'b0, cy});
      prod_a   = dx_ac * dy_bc;
      prod_b   = dx_bc * dy_ac;
      prod_a_x = $signed({{(SW-2*W-2){prod_a[2*W+1]}}, prod_a});
      prod_b_x = $signed({{(SW-2*W-2){prod_b[2*W+1]}}, prod_b});
      d        = prod_a_x - prod_b_x;
   end

endmodule

// File: rtl/point_in_triangle.sv
// Point-in-triangle: captures P1,P2,P3,PT on selPonto rising edges, then evaluates three edge signs serially.
// Latency: LEDG/ready valid 3 cycles after the PT capture edge; result held until the next capture.
// Backpressure: presses during evaluation are dropped. Macro EDGE_STRICT_EN makes boundary points count as outside.
module point_in_triangle
   import pit_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic [W-1:0]  px,
   input  logic [W-1:0]  py,
   input  logic          selPonto,
   output logic          LEDG,
   output logic          ready,
   output logic [1:0]    pointIdx
);

   state_t               state_q, state_d;
   logic [1:0]           idx_q, idx_d;
   logic [1:0]           k_q, k_d;
   logic                 sel_q;
   logic                 sel_edge;

   logic [W-1:0]         xs_q [0:3];
   logic [W-1:0]         xs_d [0:3];
   logic [W-1:0]         ys_q [0:3];
   logic [W-1:0]         ys_d [0:3];

   logic signed [SW-1:0] d1_q, d1_d;
   logic signed [SW-1:0] d2_q, d2_d;
   logic signed [SW-1:0] d3_q, d3_d;
   logic                 ledg_q, ledg_d;
   logic                 ready_q, ready_d;

   logic [1:0]           b_sel;
   logic [1:0]           c_sel;
   logic signed [SW-1:0] d_w;

   assign sel_edge = selPonto & ~sel_q;

   // Pick the edge for step k: (P1,P2), (P2,P3), (P3,P1), always tested against PT.
   always_comb begin
      b_sel = P1;
      c_sel = P2;
      unique case (k_q)
         2'd0:    begin b_sel = P1; c_sel = P2; end
         2'd1:    begin b_sel = P2; c_sel = P3; end
         default: begin b_sel = P3; c_sel = P1; end
      endcase
   end

   edge_sign u_edge_sign (
      .ax (xs_q[PT]),
      .ay (ys_q[PT]),
      .bx (xs_q[b_sel]),
      .by (ys_q[b_sel]),
      .cx (xs_q[c_sel]),
      .cy (ys_q[c_sel]),
      .d  (d_w)
   );

   // Next-state: point capture, serial sign steps and result update.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      k_d     = k_q;
      xs_d    = xs_q;
      ys_d    = ys_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      d3_d    = d3_q;
      ledg_d  = ledg_q;
      ready_d = ready_q;

      unique case (state_q)
         LOAD: begin
            if (sel_edge) begin
               xs_d[idx_q] = px;
               ys_d[idx_q] = py;
               idx_d       = idx_q + 2'd1;
               if (idx_q == PT) begin
                  state_d = CALC;
                  k_d     = 2'd0;
               end
            end
         end

         CALC: begin
            unique case (k_q)
               2'd0: begin
                  d1_d = d_w;
                  k_d  = 2'd1;
               end
               2'd1: begin
                  d2_d = d_w;
                  k_d  = 2'd2;
               end
               default: begin
                  d3_d    = d_w;
                  ledg_d  = pit_inside(d1_q, d2_q, d_w);
                  ready_d = 1'b1;
                  k_d     = 2'd0;
                  state_d = DONE;
               end
            endcase
         end

         DONE: begin
            // Result is re-derived from the stored signs, so it holds steadily.
            ledg_d = pit_inside(d1_q, d2_q, d3_q);
            if (sel_edge) begin
               xs_d[P1] = px;
               ys_d[P1] = py;
               idx_d    = P2;
               ledg_d   = 1'b0;
               ready_d  = 1'b0;
               state_d  = LOAD;
            end
         end

         default: begin
            state_d = LOAD;
            idx_d   = P1;
            ledg_d  = 1'b0;
            ready_d = 1'b0;
         end
      endcase
   end

   // State registers; selPonto_q resets high so a held button is not a press.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOAD;
         idx_q   <= P1;
         k_q     <= 2'd0;
         sel_q   <= 1'b1;
         xs_q    <= '{default: '0};
         ys_q    <= '{default: '0};
         d1_q    <= '0;
         d2_q    <= '0;
         d3_q    <= '0;
         ledg_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         k_q     <= k_d;
         sel_q   <= selPonto;
         xs_q    <= xs_d;
         ys_q    <= ys_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         d3_q    <= d3_d;
         ledg_q  <= ledg_d;
         ready_q <= ready_d;
      end
   end

   assign LEDG     = ledg_q;
   assign ready    = ready_q;
   assign pointIdx = idx_q;

endmodule
